// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch stage: PC, single-outstanding imem read, and a
// 2-entry {pc, instr} buffer feeding decode over valid/ready, with redirect flush.
module instr_fetch #(
   parameter int             N        = 64,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   input  logic         redirect,
   input  logic [N-1:0] redirect_pc,
   output logic         dec_valid,
   input  logic         dec_ready,
   output logic [31:0]  dec_instr,
   output logic [N-1:0] dec_pc
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

   localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};
   localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};

   state_t       state, state_next;
   logic [N-1:0] pc, req_pc;
   logic [N-1:0] fifo_pc    [2];
   logic [31:0]  fifo_instr [2];
   logic         wr_ptr, rd_ptr;
   logic [1:0]   count;
   logic [N-1:0] last_pc;
   logic [31:0]  last_instr;
   logic         issue, push, pop, outstanding;

   assign outstanding = (state != S_FETCH);
   assign dec_valid   = (count != 2'd0);
   assign pop         = dec_valid && dec_ready && !redirect;
   assign imem_req    = issue;
   assign imem_addr   = pc;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; combinational blocks use blocking (=) with defaults first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_next;
   end

   // A redirect with a read in flight must still swallow that stale response.
   always_comb begin
      state_next = state;
      if (redirect) begin
         state_next = (outstanding && !imem_rvalid) ? S_DROP : S_FETCH;
      end else begin
         unique case (state)
            S_FETCH:        if (issue)       state_next = S_WAIT;
            S_WAIT, S_DROP: if (imem_rvalid) state_next = S_FETCH;
            default:                         state_next = S_FETCH;
         endcase
      end
   end

   always_comb begin
      issue = reset_n && (state == S_FETCH) && (count != 2'd2) && !redirect;
      push  = (state == S_WAIT) && imem_rvalid && !redirect;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc         <= RESET_PC;
         req_pc     <= '0;
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         last_pc    <= '0;
         last_instr <= '0;
      end else begin
         if (dec_valid) begin
            last_pc    <= fifo_pc[rd_ptr];
            last_instr <= fifo_instr[rd_ptr];
         end
         if (redirect) begin
            pc     <= redirect_pc & ALIGN_MASK;
            count  <= 2'd0;
            wr_ptr <= rd_ptr;
         end else begin
            if (issue) begin
               pc     <= pc + PC_STEP;
               req_pc <= pc;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // NOTE: buffer storage is not reset; count gates every read, so its contents
   // are only observed after a push has written them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= req_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

   // When empty, the last presented entry is held rather than the stale slot.
   assign dec_instr = dec_valid ? fifo_instr[rd_ptr] : last_instr;
   assign dec_pc    = dec_valid ? fifo_pc[rd_ptr]    : last_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a variable-latency memory model answers each
// request; per-scenario tasks check hand-computed cycle-accurate expectations.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic [10:0] op;

   int errors = 0;
   int checks = 0;
   int lat = 1;

   assign op = dec_instr[31:21];

   instr_fetch #(.N(64), .RESET_PC(64'h0)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0:   return 32'hF840_0000;
         64'h4:   return 32'hF800_0000;
         default: return {8'hD1, a[23:0]};
      endcase
   endfunction

   // Memory model: request seen mid-cycle, data returned lat cycles later.
   initial begin
      logic [63:0] ma;
      forever begin
         @(negedge clk);
         if (reset_n && imem_req) begin
            ma = imem_addr;
            repeat (lat) @(posedge clk);
            #1;
            if (reset_n) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(ma);
            end
            @(posedge clk);
            #1 imem_rvalid = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic do_reset(input int l, input logic rdy);
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      dec_ready   = rdy;
      lat         = l;
      repeat (6) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", dec_valid); end
      checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", dec_instr); end
      checks++; if (dec_pc !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", dec_pc); end
      do_reset(1, 1'b1);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_no_req: got %b want 0", imem_req); end
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'hF840_0000 || dec_pc !== 64'h0) begin errors++; $display("FAIL first_instr: got v=%b %h pc=%h want 1 f8400000 0", dec_valid, dec_instr, dec_pc); end
      checks++; if (op !== 11'h7C2) begin errors++; $display("FAIL first_op: got %h want 7c2", op); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin errors++; $display("FAIL second_req: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
      @(negedge clk);
      checks++; if (dec_valid !== 1'b0 || dec_instr !== 32'hF840_0000) begin errors++; $display("FAIL hold_empty: got v=%b %h want 0 f8400000", dec_valid, dec_instr); end
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'hF800_0000 || dec_pc !== 64'h4) begin errors++; $display("FAIL second_instr: got v=%b %h pc=%h want 1 f8000000 4", dec_valid, dec_instr, dec_pc); end
      checks++; if (op !== 11'h7C0) begin errors++; $display("FAIL second_op: got %h want 7c0", op); end
   endtask

   task automatic test_backpressure;
      int nreq = 0;
      logic [63:0] addrs [4];
      do_reset(1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req) begin
            if (nreq < 4) addrs[nreq] = imem_addr;
            nreq++;
         end
         @(posedge clk);
         #1;
      end
      checks++; if (nreq !== 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", nreq); end
      if (nreq >= 2) begin
         checks++; if (addrs[0] !== 64'h0 || addrs[1] !== 64'h4) begin errors++; $display("FAIL bp_addrs: got %h %h want 0 4", addrs[0], addrs[1]); end
      end
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'hF840_0000 || dec_pc !== 64'h0) begin errors++; $display("FAIL bp_stable: got v=%b %h pc=%h want 1 f8400000 0", dec_valid, dec_instr, dec_pc); end
      dec_ready = 1'b1;
      @(negedge clk);
      checks++; if (dec_pc !== 64'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_pop: got pc=%h req=%b want 0 0", dec_pc, imem_req); end
      @(posedge clk);
      #1 dec_ready = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8 || dec_pc !== 64'h4) begin errors++; $display("FAIL bp_resume: got req=%b addr=%h pc=%h want 1 8 4", imem_req, imem_addr, dec_pc); end
   endtask

   task automatic test_redirect_outstanding;
      logic found = 1'b0;
      logic stale = 1'b0;
      int rv_cyc = -1;
      int rq_cyc = -1;
      logic [63:0] rq_addr = '1;
      logic [63:0] first_pc = '1;
      logic got_first = 1'b0;
      do_reset(3, 1'b1);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 64'h8) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!found) begin errors++; $display("FAIL ro_find_req8: got none want request at 8"); end
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 64'h100;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ro_req_in_redirect: got %b want 0", imem_req); end
      @(posedge clk);
      #1 redirect = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL ro_flush: got %b want 0", dec_valid); end
         end
         if (imem_rvalid && rv_cyc < 0) rv_cyc = i;
         if (imem_req && rq_cyc < 0) begin rq_cyc = i; rq_addr = imem_addr; end
         if (dec_valid && dec_pc == 64'h8) stale = 1'b1;
         if (dec_valid && !got_first) begin got_first = 1'b1; first_pc = dec_pc; end
         @(posedge clk);
         #1;
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL ro_stale: got stale pc 8 presented want never"); end
      checks++; if (rv_cyc !== 1 || rq_cyc !== 2) begin errors++; $display("FAIL ro_timing: got rvalid@%0d req@%0d want 1 2", rv_cyc, rq_cyc); end
      checks++; if (rq_addr !== 64'h100) begin errors++; $display("FAIL ro_target: got %h want 100", rq_addr); end
      checks++; if (first_pc !== 64'h100) begin errors++; $display("FAIL ro_first_pc: got %h want 100", first_pc); end
   endtask

   task automatic test_simultaneous;
      do_reset(1, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      redirect = 1'b1; redirect_pc = 64'h200; dec_ready = 1'b1;
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL sim_pre: got v=%b pc=%h req=%b want 1 0 0", dec_valid, dec_pc, imem_req); end
      @(posedge clk);
      #1 redirect = 1'b0; dec_ready = 1'b0;
      @(negedge clk);
      checks++; if (dec_valid !== 1'b0 || dec_pc !== 64'h0) begin errors++; $display("FAIL sim_flush: got v=%b pc=%h want 0 0", dec_valid, dec_pc); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin errors++; $display("FAIL sim_target: got req=%b addr=%h want 1 200", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h200 || dec_instr !== 32'hD100_0200) begin errors++; $display("FAIL sim_deliver: got v=%b pc=%h %h want 1 200 d1000200", dec_valid, dec_pc, dec_instr); end
   endtask

   task automatic test_align_wrap;
      do_reset(1, 1'b1);
      redirect = 1'b1; redirect_pc = 64'h103;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL aw_req_blocked: got %b want 0", imem_req); end
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin errors++; $display("FAIL aw_align: got req=%b addr=%h want 1 100", imem_req, imem_addr); end
      repeat (2) begin @(posedge clk); #1; end
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h100) begin errors++; $display("FAIL aw_deliver: got v=%b pc=%h want 1 100", dec_valid, dec_pc); end
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL aw_top: got req=%b addr=%h want 1 fffffffffffffffc", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL aw_wrap: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL aw_wrap_pc: got v=%b pc=%h want 1 fffffffffffffffc", dec_valid, dec_pc); end
   endtask

   task automatic test_async_reset;
      do_reset(1, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL ar_full: got v=%b req=%b want 1 0", dec_valid, imem_req); end
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ar_immediate: got v=%b req=%b want 0 0", dec_valid, imem_req); end
      checks++; if (dec_pc !== 64'h0 || dec_instr !== 32'h0) begin errors++; $display("FAIL ar_outputs: got pc=%h instr=%h want 0 0", dec_pc, dec_instr); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || dec_valid !== 1'b0) begin errors++; $display("FAIL ar_restart: got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, dec_valid); end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_redirect_outstanding();
      test_simultaneous();
      test_align_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
